// File: rtl/action_msg_pkg.sv
// Shared constants for the action-message decoder: type codes, field positions,
// pitch limit and point values.
package action_msg_pkg;

  typedef enum logic [2:0] {
    MT_NONE          = 3'd0,
    MT_ON_TIME       = 3'd1,
    MT_LATE          = 3'd2,
    MT_RELEASE_OK    = 3'd3,
    MT_MISS          = 3'd4,
    MT_EARLY_RELEASE = 3'd5,
    MT_WRONG_KEY     = 3'd6,
    MT_RESERVED      = 3'd7
  } msg_type_e;

  localparam int MSG_W     = 9;
  localparam int TYPE_MSB  = 8;
  localparam int TYPE_LSB  = 6;
  localparam int PITCH_MSB = 5;
  localparam int PITCH_LSB = 0;

  localparam logic [5:0] MAX_PITCH = 6'd60;

  localparam logic [3:0] PTS_ON_TIME    = 4'd4;
  localparam logic [3:0] PTS_LATE       = 4'd2;
  localparam logic [3:0] PTS_RELEASE_OK = 4'd1;

  localparam int BONUS_STREAK = 8;

endpackage

// File: rtl/action_msg_fifo.sv
// Generic synchronous first-word-fall-through FIFO; dout always shows the head entry.
module action_msg_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/action_msg_decoder.sv
// Action-message decoder: filters and buffers incoming messages, presents events over
// valid/ready and keeps score/streak. Optional macro: ACTION_STREAK_BONUS_EN.
module action_msg_decoder
  import action_msg_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SCORE_W  = 16,
  parameter int STREAK_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8:0]              msg,
  input  logic                    msg_enable,
  input  logic                    ev_ready,
  output logic                    ev_valid,
  output logic [2:0]              ev_type,
  output logic [5:0]              ev_pitch,
  output logic [SCORE_W-1:0]      score,
  output logic [STREAK_W-1:0]     streak,
  output logic [STREAK_W-1:0]     best_streak,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    bad_pitch
);

  logic [2:0]       in_type;
  logic [5:0]       in_pitch;
  logic             is_msg;
  logic             pitch_ok;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [MSG_W-1:0] head;

  assign in_type  = msg[TYPE_MSB:TYPE_LSB];
  assign in_pitch = msg[PITCH_MSB:PITCH_LSB];
  assign is_msg   = msg_enable && (in_type != MT_NONE);
  assign pitch_ok = (in_pitch <= MAX_PITCH);
  assign pop      = ev_valid && ev_ready;
  assign push     = is_msg && pitch_ok && (!full || pop);

  action_msg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MSG_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (msg),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Head fields are forced to zero when empty so the outputs read 0 out of reset.
  assign ev_valid = !empty;
  assign ev_type  = ev_valid ? head[TYPE_MSB:TYPE_LSB]   : 3'd0;
  assign ev_pitch = ev_valid ? head[PITCH_MSB:PITCH_LSB] : 6'd0;

  logic [3:0]          points;
  logic                streak_inc;
  logic                streak_clr;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_n;
  logic [STREAK_W-1:0] streak_n;
  logic [STREAK_W-1:0] best_n;

  always_comb begin
    points     = 4'd0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    if (pop) begin
      case (msg_type_e'(ev_type))
        MT_ON_TIME:       begin points = PTS_ON_TIME;    streak_inc = 1'b1; end
        MT_LATE:          begin points = PTS_LATE;       streak_inc = 1'b1; end
        MT_RELEASE_OK:    points = PTS_RELEASE_OK;
        MT_MISS,
        MT_EARLY_RELEASE,
        MT_WRONG_KEY:     streak_clr = 1'b1;
        default:          points = 4'd0;
      endcase
`ifdef ACTION_STREAK_BONUS_EN
      // Bonus is judged on the streak before this hit is counted.
      if (streak_inc && (streak >= STREAK_W'(BONUS_STREAK))) points = points << 1;
`endif
    end

    score_sum = {1'b0, score} + (SCORE_W+1)'(points);
    score_n   = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    streak_n = streak;
    if (streak_clr)                          streak_n = '0;
    else if (streak_inc && (streak != '1))   streak_n = streak + 1'b1;

    best_n = (streak_n > best_streak) ? streak_n : best_streak;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score       <= '0;
      streak      <= '0;
      best_streak <= '0;
      overflow    <= 1'b0;
      bad_pitch   <= 1'b0;
    end else begin
      score       <= score_n;
      streak      <= streak_n;
      best_streak <= best_n;
      if (is_msg && !pitch_ok)                  bad_pitch <= 1'b1;
      if (is_msg && pitch_ok && full && !pop)   overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_action_msg_decoder.sv
// Self-checking bench for action_msg_decoder; expected events are queued when driven
// and compared as the DUT retires them.
module tb_action_msg_decoder;

  logic        clk;
  logic        reset;
  logic [8:0]  msg;
  logic        msg_enable;
  logic        ev_ready;
  logic        ev_valid;
  logic [2:0]  ev_type;
  logic [5:0]  ev_pitch;
  logic [15:0] score;
  logic [7:0]  streak;
  logic [7:0]  best_streak;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        bad_pitch;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pops = 0;
  logic [8:0] sb_q[$];
  logic [8:0] exp_ev;

  localparam logic [2:0] T_NONE = 3'd0, T_ON = 3'd1, T_LATE = 3'd2, T_MISS = 3'd4;

  action_msg_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .msg         (msg),
    .msg_enable  (msg_enable),
    .ev_ready    (ev_ready),
    .ev_valid    (ev_valid),
    .ev_type     (ev_type),
    .ev_pitch    (ev_pitch),
    .score       (score),
    .streak      (streak),
    .best_streak (best_streak),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .bad_pitch   (bad_pitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after posedge, so at negedge they hold the values the next edge sees.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      n_cmp++;
      n_pops++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL event_order: got type=%0d pitch=%0d, expected no event", ev_type, ev_pitch);
      end else begin
        exp_ev = sb_q.pop_front();
        if ({ev_type, ev_pitch} !== exp_ev) begin
          n_bad++;
          $display("FAIL event_order: got type=%0d pitch=%0d, expected type=%0d pitch=%0d",
                   ev_type, ev_pitch, exp_ev[8:6], exp_ev[5:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb_q.delete();
    tick();
    reset = 1'b0;
    n_pops = 0;
  endtask

  task automatic send(input logic [2:0] t, input logic [5:0] p, input bit accept);
    msg = {t, p};
    msg_enable = 1'b1;
    if (accept) sb_q.push_back({t, p});
    tick();
    msg_enable = 1'b0;
  endtask

  task automatic drain(input string name);
    ev_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!ev_valid) break;
      tick();
    end
    n_cmp++;
    if (ev_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain_timeout: ev_valid=%0b, expected 0", name, ev_valid);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_sb_left: %0d events not retired, expected 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (ev_valid !== 1'b0)     begin n_bad++; $display("FAIL rst_ev_valid: got %0b, expected 0", ev_valid); end
    n_cmp++; if (fifo_count !== 4'd0)   begin n_bad++; $display("FAIL rst_count: got %0d, expected 0", fifo_count); end
    n_cmp++; if ({ev_type, ev_pitch} !== 9'd0) begin n_bad++; $display("FAIL rst_head: got %0h, expected 0", {ev_type, ev_pitch}); end
    n_cmp++; if ({score, streak, best_streak} !== 32'd0) begin n_bad++; $display("FAIL rst_score: got %0d/%0d/%0d, expected 0/0/0", score, streak, best_streak); end
    n_cmp++; if ({overflow, bad_pitch} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %0b%0b, expected 00", overflow, bad_pitch); end
  endtask

  task automatic test_single();
    do_reset();
    ev_ready = 1'b1;
    send(T_ON, 6'd12, 1'b1);
    n_cmp++; if (ev_valid !== 1'b1)  begin n_bad++; $display("FAIL single_valid: got %0b, expected 1", ev_valid); end
    n_cmp++; if (ev_pitch !== 6'd12) begin n_bad++; $display("FAIL single_pitch: got %0d, expected 12", ev_pitch); end
    tick();
    n_cmp++; if (ev_valid !== 1'b0)  begin n_bad++; $display("FAIL single_valid_drop: got %0b, expected 0", ev_valid); end
    n_cmp++; if ({score, streak, best_streak} !== {16'd4, 8'd1, 8'd1})
      begin n_bad++; $display("FAIL single_score: got %0d/%0d/%0d, expected 4/1/1", score, streak, best_streak); end
  endtask

  task automatic test_overflow();
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(T_ON, 6'(20 + i), i < 8);
    n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d, expected 8", fifo_count); end
    n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_flag: got %0b, expected 1", overflow); end
    drain("ovf");
    n_cmp++; if (n_pops != 8) begin n_bad++; $display("FAIL ovf_pops: got %0d, expected 8", n_pops); end
    n_cmp++; if ({score, streak, best_streak} !== {16'd32, 8'd8, 8'd8})
      begin n_bad++; $display("FAIL ovf_score: got %0d/%0d/%0d, expected 32/8/8", score, streak, best_streak); end
  endtask

  task automatic test_streak();
    logic [2:0] types[5];
    logic [7:0] exp_streak[5];
    types = '{T_ON, T_ON, T_ON, T_MISS, T_LATE};
    exp_streak = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    do_reset();
    ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(types[i], 6'(40 + i), 1'b1);
      tick();
      n_cmp++;
      if (streak !== exp_streak[i]) begin n_bad++; $display("FAIL streak_step%0d: got %0d, expected %0d", i, streak, exp_streak[i]); end
    end
    n_cmp++; if (best_streak !== 8'd3) begin n_bad++; $display("FAIL streak_best: got %0d, expected 3", best_streak); end
    n_cmp++; if (score !== 16'd14)     begin n_bad++; $display("FAIL streak_score: got %0d, expected 14", score); end
  endtask

  task automatic test_full_pop();
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(T_ON, 6'(30 + i), 1'b1);
    ev_ready = 1'b1;
    send(T_LATE, 6'd50, 1'b1);
    n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL fullpop_count: got %0d, expected 8", fifo_count); end
    n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL fullpop_ovf: got %0b, expected 0", overflow); end
    drain("fullpop");
    n_cmp++; if (n_pops != 9) begin n_bad++; $display("FAIL fullpop_pops: got %0d, expected 9", n_pops); end
  endtask

  task automatic test_bad_pitch();
    do_reset();
    ev_ready = 1'b0;
    send(T_NONE, 6'd5, 1'b0);
    n_cmp++; if ({fifo_count, bad_pitch, overflow} !== 6'b0000_0_0)
      begin n_bad++; $display("FAIL none_ignored: count=%0d bad=%0b ovf=%0b, expected 0/0/0", fifo_count, bad_pitch, overflow); end
    send(T_ON, 6'd61, 1'b0);
    n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL badp_count: got %0d, expected 0", fifo_count); end
    n_cmp++; if (bad_pitch !== 1'b1)  begin n_bad++; $display("FAIL badp_flag: got %0b, expected 1", bad_pitch); end
    send(T_ON, 6'd60, 1'b1);
    n_cmp++; if (fifo_count !== 4'd1) begin n_bad++; $display("FAIL pitch60_count: got %0d, expected 1", fifo_count); end
    n_cmp++; if (score !== 16'd0)     begin n_bad++; $display("FAIL badp_score: got %0d, expected 0", score); end
    drain("badp");
    n_cmp++; if (score !== 16'd4)     begin n_bad++; $display("FAIL pitch60_score: got %0d, expected 4", score); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ev_ready = 1'b0;
    send(T_ON, 6'd1, 1'b1);
    send(T_LATE, 6'd2, 1'b1);
    drain("mid_pre");
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(T_ON, 6'(10 + i), 1'b1);
    n_cmp++; if (fifo_count !== 4'd5 || score !== 16'd6)
      begin n_bad++; $display("FAIL mid_pre_state: count=%0d score=%0d, expected 5/6", fifo_count, score); end
    ev_ready = 1'b1;
    do_reset();
    n_cmp++; if ({ev_valid, fifo_count} !== 5'd0) begin n_bad++; $display("FAIL mid_queue: valid=%0b count=%0d, expected 0/0", ev_valid, fifo_count); end
    n_cmp++; if ({score, streak, best_streak} !== 32'd0)
      begin n_bad++; $display("FAIL mid_score: got %0d/%0d/%0d, expected 0/0/0", score, streak, best_streak); end
  endtask

  task automatic test_bonus();
    logic [15:0] exp_score;
`ifdef ACTION_STREAK_BONUS_EN
    exp_score = 16'd48;
`else
    exp_score = 16'd40;
`endif
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(T_ON, 6'(i), 1'b1);
    drain("bonus_a");
    ev_ready = 1'b0;
    send(T_ON, 6'd8, 1'b1);
    send(T_ON, 6'd9, 1'b1);
    drain("bonus_b");
    n_cmp++; if (score !== exp_score) begin n_bad++; $display("FAIL bonus_score: got %0d, expected %0d", score, exp_score); end
    n_cmp++; if ({streak, best_streak} !== {8'd10, 8'd10})
      begin n_bad++; $display("FAIL bonus_streak: got %0d/%0d, expected 10/10", streak, best_streak); end
  endtask

  initial begin
    reset = 1'b1;
    msg = 9'd0;
    msg_enable = 1'b0;
    ev_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_single();
    test_overflow();
    test_streak();
    test_full_pop();
    test_bad_pitch();
    test_reset_mid();
    test_bonus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
